jedro_1_imem_resp: RTL

Instruction-memory responder: the RAM end of the core's instruction fetch interface. It accepts fetch requests (enable + byte address) and returns the addressed 32-bit word after a fixed, configurable latency. A separate write port preloads the program from the loader or debug path. It sits between the fetch stage and on-chip instruction storage.

---
 rtl/jedro_1_imem_resp_pkg.sv | 23 ++
 rtl/jedro_1_imem_resp_if.sv | 26 ++
 rtl/jedro_1_imem_resp_ram.sv | 51 +++++
 rtl/jedro_1_imem_resp.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/jedro_1_imem_resp_pkg.sv
// Shared definitions for the jedro_1 instruction-memory responder:
// bus widths, the NOP instruction word, FSM state encodings and the
// parity helper used when JEDRO_1_IMEM_PARITY_EN is defined.
package jedro_1_imem_resp_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  // addi x0, x0, 0 -- returned on faults and after reset
  localparam logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IMEM_IDLE = 2'd0,
    IMEM_WAIT = 2'd1,
    IMEM_RESP = 2'd2
  } imem_state_e;

  // Even-parity bit: stored alongside the word so the whole codeword XORs to 0
  function automatic logic even_parity(input logic [DATA_WIDTH-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/jedro_1_imem_resp_if.sv
// Fetch + load bus between the core/loader (master) and the instruction
// memory responder (slave). Signal names follow the responder's view.
interface jedro_1_imem_resp_if;
  import jedro_1_imem_resp_pkg::*;

  logic                  en_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic                  gnt_o;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  rvalid_o;
  logic                  err_o;
  logic                  we_i;
  logic [ADDR_WIDTH-1:0] waddr_i;
  logic [DATA_WIDTH-1:0] wdata_i;

  modport master (
    output en_i, addr_i, we_i, waddr_i, wdata_i,
    input  gnt_o, data_o, rvalid_o, err_o
  );

  modport slave (
    input  en_i, addr_i, we_i, waddr_i, wdata_i,
    output gnt_o, data_o, rvalid_o, err_o
  );

endinterface

// File: rtl/jedro_1_imem_resp_ram.sv
// jedro_1_imem_ram: synchronous instruction storage, one write port and one
// registered read port. With JEDRO_1_IMEM_PARITY_EN each word carries an
// extra even-parity bit and the read port flags a parity mismatch.
// The read register only updates when re_i is high, so rdata_o holds.
module jedro_1_imem_ram
  import jedro_1_imem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [IDX_W-1:0]      raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rpar_err_o
);

`ifdef JEDRO_1_IMEM_PARITY_EN
  localparam int W_WORD = DATA_WIDTH + 1;
`else
  localparam int W_WORD = DATA_WIDTH;
`endif

  logic [W_WORD-1:0] r_mem [DEPTH_WORDS];
  logic [W_WORD-1:0] r_rword;
  logic [W_WORD-1:0] w_wword;

`ifdef JEDRO_1_IMEM_PARITY_EN
  assign w_wword    = {even_parity(wdata_i), wdata_i};
  assign rpar_err_o = ^r_rword;
`else
  assign w_wword    = wdata_i;
  assign rpar_err_o = 1'b0;
`endif

  // Storage write and registered read; a same-cycle read sees the old word
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem[waddr_i] <= w_wword;
    end
    if (re_i) begin
      r_rword <= r_mem[raddr_i];
    end
  end

  assign rdata_o = r_rword[DATA_WIDTH-1:0];

endmodule

// File: rtl/jedro_1_imem_resp.sv
// jedro_1_imem_resp: RAM end of the instruction fetch interface.
// Accepts enable + byte-address requests, answers with one rvalid_o pulse
// 1+WAIT_STATES cycles after the grant, flags misaligned/out-of-range
// fetches with err_o and a NOP word. A load port preloads the program.
// Optional feature macro: JEDRO_1_IMEM_PARITY_EN (per-word parity check).
module jedro_1_imem_resp
  import jedro_1_imem_resp_pkg::*;
#(
  parameter int                    DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int                    WAIT_STATES = 0
) (
  input logic               clk_i,
  input logic               rst_i,
  jedro_1_imem_resp_if.slave bus
);

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [2:0] CNT_LAST = 3'(WAIT_STATES - 1);

  typedef struct packed {
    logic             fault;
    logic [IDX_W-1:0] idx;
  } addr_dec_t;

  // Byte address -> word index plus fault flag (misaligned, below base, past end)
  function automatic addr_dec_t decode(input logic [ADDR_WIDTH-1:0] a);
    logic                  borrow;
    logic [ADDR_WIDTH-1:0] off;
    addr_dec_t             r;
    {borrow, off} = {1'b0, a} - {1'b0, BASE_ADDR};
    r.idx   = IDX_W'(off >> 2);
    r.fault = (a[1:0] != 2'b00) || borrow ||
              ((off >> (IDX_W + 2)) != {ADDR_WIDTH{1'b0}});
    return r;
  endfunction

  imem_state_e           r_state;
  logic [2:0]            r_cnt;
  logic                  r_fault;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_nop;
  logic                  r_rvalid;

  addr_dec_t             w_rdec;
  addr_dec_t             w_wdec;
  logic                  w_gnt;
  logic                  w_sample;
  logic                  w_sample_fault;
  logic                  w_ram_re;
  logic                  w_ram_we;
  logic [IDX_W-1:0]      w_ram_raddr;
  logic [DATA_WIDTH-1:0] w_ram_rdata;
  logic                  w_par_err;

  assign w_rdec = decode(bus.addr_i);
  assign w_wdec = decode(bus.waddr_i);

  // Grant, read-sample timing and load-write qualification
  always_comb begin
    w_gnt          = 1'b0;
    w_sample       = 1'b0;
    w_sample_fault = 1'b0;
    w_ram_raddr    = w_rdec.idx;
    if (bus.en_i && ((r_state == IMEM_IDLE) ||
                     ((r_state == IMEM_RESP) && (WAIT_STATES == 0)))) begin
      w_gnt = 1'b1;
    end else begin
      w_gnt = 1'b0;
    end
    if (r_state == IMEM_WAIT) begin
      // Last wait cycle reads the latched address
      w_sample       = (r_cnt == CNT_LAST);
      w_sample_fault = r_fault;
      w_ram_raddr    = r_idx;
    end else begin
      // Zero wait states: the grant cycle itself is the read-sample cycle
      w_sample       = w_gnt && (WAIT_STATES == 0);
      w_sample_fault = w_rdec.fault;
      w_ram_raddr    = w_rdec.idx;
    end
    w_ram_re = w_sample && !w_sample_fault;
    w_ram_we = bus.we_i && !w_wdec.fault;
  end

  // Request FSM with registered valid and NOP-select outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= IMEM_IDLE;
      r_cnt    <= 3'd0;
      r_fault  <= 1'b0;
      r_idx    <= {IDX_W{1'b0}};
      r_nop    <= 1'b1;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      case (r_state)
        IMEM_IDLE, IMEM_RESP: begin
          if (w_gnt) begin
            r_fault <= w_rdec.fault;
            r_idx   <= w_rdec.idx;
            r_cnt   <= 3'd0;
            if (WAIT_STATES == 0) begin
              r_state  <= IMEM_RESP;
              r_rvalid <= 1'b1;
              r_nop    <= w_rdec.fault;
            end else begin
              r_state  <= IMEM_WAIT;
            end
          end else begin
            r_state <= IMEM_IDLE;
          end
        end
        IMEM_WAIT: begin
          if (r_cnt == CNT_LAST) begin
            r_state  <= IMEM_RESP;
            r_rvalid <= 1'b1;
            r_nop    <= r_fault;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        default: begin
          r_state <= IMEM_IDLE;
        end
      endcase
    end
  end

  jedro_1_imem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clk_i      (clk_i),
    .we_i       (w_ram_we),
    .waddr_i    (w_wdec.idx),
    .wdata_i    (bus.wdata_i),
    .re_i       (w_ram_re),
    .raddr_i    (w_ram_raddr),
    .rdata_o    (w_ram_rdata),
    .rpar_err_o (w_par_err)
  );

  // The read register holds between responses, so data_o holds too;
  // an address fault overrides it with NOP, a parity fault shows the raw word.
  assign bus.gnt_o    = w_gnt;
  assign bus.rvalid_o = r_rvalid;
  assign bus.data_o   = r_nop ? NOP_INSTR : w_ram_rdata;
  assign bus.err_o    = r_rvalid && (r_fault || w_par_err);

endmodule
